// File: rtl/motor_dir_ctrl.sv
// motor_dir_ctrl
//   Turns a 3-bit motion command into L298N-style H-bridge drive for two
//   wheels. The command is debounced, a watchdog forces stop when the
//   upstream controller stops refreshing, and any wheel direction reversal
//   passes through a dead-time window with both bridges off.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd[2:0], cmd_valid   motion command and its refresh strobe
//   pwm_255..pwm_0        fixed-duty PWM lines from the PWM stage
//   left_in/right_in[1:0] bridge inputs: 10 fwd, 01 rev, 00 off
//   left_en/right_en      bridge enables (selected PWM line, gated)
//   state_o[1:0]          00 STOP, 01 RUN, 10 DEAD
//   wdog_trip             high while the watchdog forces stop
module motor_dir_ctrl #(
    parameter int unsigned STABLE_CYC = 1000,
    parameter int unsigned DEAD_CYC   = 50000,
    parameter int unsigned WDOG_CYC   = 25000000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] cmd,
    input  logic       cmd_valid,
    input  logic       pwm_255,
    input  logic       pwm_250,
    input  logic       pwm_220,
    input  logic       pwm_150,
    input  logic       pwm_0,
    output logic [1:0] left_in,
    output logic [1:0] right_in,
    output logic       left_en,
    output logic       right_en,
    output logic [1:0] state_o,
    output logic       wdog_trip
);
    typedef enum logic [1:0] {ST_STOP = 2'b00, ST_RUN = 2'b01, ST_DEAD = 2'b10} state_e;
    typedef enum logic [2:0] {D255, D250, D220, D150, D0} duty_e;

    localparam logic [1:0] DIR_OFF = 2'b00;
    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] WDOG_MAX    = CNT_W'(WDOG_CYC);

    // ---------------- debounce ----------------
    logic [2:0]       cand_q, acc_q;
    logic [CNT_W-1:0] stab_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= 3'b000;
            stab_q <= '0;
            acc_q  <= 3'b000;
        end else if (cmd != cand_q) begin
            cand_q <= cmd;
            stab_q <= '0;
        end else if (stab_q == STABLE_LAST) begin
            // counter parks here; re-accepting the same value is harmless
            acc_q <= cand_q;
        end else begin
            stab_q <= stab_q + 1'b1;
        end
    end

    // ---------------- watchdog ----------------
    logic [CNT_W-1:0] wdog_q;
    logic             trip_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            trip_q <= 1'b1;
        end else if (cmd_valid) begin
            wdog_q <= '0;
            trip_q <= 1'b0;
        end else if (wdog_q != WDOG_MAX) begin
            wdog_q <= wdog_q + 1'b1;
            if (wdog_q == WDOG_MAX - 1'b1) trip_q <= 1'b1;
        end
    end

    // ---------------- target decode ----------------
    logic [2:0] eff_cmd;
    logic [1:0] tgt_l_dir, tgt_r_dir;
    duty_e      tgt_l_sel, tgt_r_sel;
    logic       tgt_stop;

    assign eff_cmd = trip_q ? 3'b000 : acc_q;

    always_comb begin
        tgt_l_dir = DIR_OFF; tgt_l_sel = D0;
        tgt_r_dir = DIR_OFF; tgt_r_sel = D0;
        case (eff_cmd)
            3'b001: begin tgt_l_dir = DIR_FWD; tgt_l_sel = D255; tgt_r_dir = DIR_FWD; tgt_r_sel = D255; end
            3'b010: begin tgt_l_dir = DIR_REV; tgt_l_sel = D220; tgt_r_dir = DIR_REV; tgt_r_sel = D220; end
            3'b011: begin tgt_l_dir = DIR_FWD; tgt_l_sel = D150; tgt_r_dir = DIR_FWD; tgt_r_sel = D250; end
            3'b100: begin tgt_l_dir = DIR_FWD; tgt_l_sel = D250; tgt_r_dir = DIR_FWD; tgt_r_sel = D150; end
            3'b101: begin tgt_l_dir = DIR_REV; tgt_l_sel = D220; tgt_r_dir = DIR_FWD; tgt_r_sel = D220; end
            3'b110: begin tgt_l_dir = DIR_FWD; tgt_l_sel = D220; tgt_r_dir = DIR_REV; tgt_r_sel = D220; end
            default: ;
        endcase
    end

    // every non-stop command drives both wheels, so left off means stop
    assign tgt_stop = (tgt_l_dir == DIR_OFF);

    function automatic logic opposite(input logic [1:0] a, input logic [1:0] b);
        return (a == DIR_FWD && b == DIR_REV) || (a == DIR_REV && b == DIR_FWD);
    endfunction

    // ---------------- FSM ----------------
    state_e           state_q, state_d;
    logic [1:0]       l_dir_q, l_dir_d, r_dir_q, r_dir_d;
    duty_e            l_sel_q, l_sel_d, r_sel_q, r_sel_d;
    logic             run_l_q, run_l_d, run_r_q, run_r_d;
    logic [CNT_W-1:0] dead_q, dead_d;
    logic             apply, go_off, reversal;

    assign reversal = opposite(l_dir_q, tgt_l_dir) || opposite(r_dir_q, tgt_r_dir);

    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        apply   = 1'b0;
        go_off  = 1'b0;
        case (state_q)
            ST_STOP: if (!tgt_stop) begin state_d = ST_RUN; apply = 1'b1; end
            ST_RUN: begin
                if (tgt_stop) begin
                    state_d = ST_STOP; go_off = 1'b1;
                end else if (reversal) begin
                    state_d = ST_DEAD; go_off = 1'b1; dead_d = DEAD_LAST;
                end else begin
                    apply = 1'b1;
                end
            end
            ST_DEAD: begin
                // outputs are already off here; only the exit matters
                if (tgt_stop)            state_d = ST_STOP;
                else if (dead_q == '0) begin state_d = ST_RUN; apply = 1'b1; end
                else                     dead_d = dead_q - 1'b1;
            end
            default: begin state_d = ST_STOP; go_off = 1'b1; end
        endcase

        l_dir_d = l_dir_q; r_dir_d = r_dir_q;
        l_sel_d = l_sel_q; r_sel_d = r_sel_q;
        run_l_d = run_l_q; run_r_d = run_r_q;
        if (apply) begin
            l_dir_d = tgt_l_dir; r_dir_d = tgt_r_dir;
            l_sel_d = tgt_l_sel; r_sel_d = tgt_r_sel;
            run_l_d = 1'b1;      run_r_d = 1'b1;
        end else if (go_off) begin
            l_dir_d = DIR_OFF;   r_dir_d = DIR_OFF;
            l_sel_d = D0;        r_sel_d = D0;
            run_l_d = 1'b0;      run_r_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            dead_q  <= '0;
            l_dir_q <= DIR_OFF; r_dir_q <= DIR_OFF;
            l_sel_q <= D0;      r_sel_q <= D0;
            run_l_q <= 1'b0;    run_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dead_q  <= dead_d;
            l_dir_q <= l_dir_d; r_dir_q <= r_dir_d;
            l_sel_q <= l_sel_d; r_sel_q <= r_sel_d;
            run_l_q <= run_l_d; run_r_q <= run_r_d;
        end
    end

    // ---------------- outputs ----------------
    function automatic logic pick(input duty_e s, input logic [4:0] v);
        case (s)
            D255:    return v[0];
            D250:    return v[1];
            D220:    return v[2];
            D150:    return v[3];
            D0:      return v[4];
            default: return 1'b0;
        endcase
    endfunction

    logic [4:0] pwm_vec;
    assign pwm_vec = {pwm_0, pwm_150, pwm_220, pwm_250, pwm_255};

    // enables follow the live PWM lines through the registered select
    assign left_en   = run_l_q && pick(l_sel_q, pwm_vec);
    assign right_en  = run_r_q && pick(r_sel_q, pwm_vec);
    assign left_in   = l_dir_q;
    assign right_in  = r_dir_q;
    assign state_o   = state_q;
    assign wdog_trip = trip_q;

endmodule

// File: tb/tb_motor_dir_ctrl.sv
module tb_motor_dir_ctrl;
    localparam int STABLE = 4;
    localparam int DEAD   = 8;
    localparam int WDOG   = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cmd = 3'b000;
    logic       cmd_valid = 1'b0;
    logic       pwm_255 = 0, pwm_250 = 0, pwm_220 = 0, pwm_150 = 0, pwm_0 = 0;
    logic [1:0] left_in, right_in, state_o;
    logic       left_en, right_en, wdog_trip;

    motor_dir_ctrl #(.STABLE_CYC(STABLE), .DEAD_CYC(DEAD), .WDOG_CYC(WDOG), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
        .pwm_255(pwm_255), .pwm_250(pwm_250), .pwm_220(pwm_220),
        .pwm_150(pwm_150), .pwm_0(pwm_0),
        .left_in(left_in), .right_in(right_in), .left_en(left_en), .right_en(right_en),
        .state_o(state_o), .wdog_trip(wdog_trip)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- background stimulus: PWM noise and refresh pulses ----------------
    bit pulse_en = 1'b1;
    int vcyc = 0;
    always @(posedge clk) begin
        #1;
        pwm_255 = 1'($urandom_range(0, 1));
        pwm_250 = 1'($urandom_range(0, 1));
        pwm_220 = 1'($urandom_range(0, 1));
        pwm_150 = 1'($urandom_range(0, 1));
        pwm_0   = 1'($urandom_range(0, 1));
        if (!rst_n) begin
            vcyc = 0; cmd_valid = 1'b0;
        end else begin
            cmd_valid = pulse_en && (vcyc % 10 == 0);
            vcyc++;
        end
    end

    // ---------------- reference model ----------------
    // duty index: 0=pwm_255 1=pwm_250 2=pwm_220 3=pwm_150 4=pwm_0
    function automatic void target(input logic [2:0] c, output logic [1:0] ld, output logic [1:0] rd,
                                   output int ls, output int rs);
        case (c)
            3'b001: begin ld = 2'b10; ls = 0; rd = 2'b10; rs = 0; end
            3'b010: begin ld = 2'b01; ls = 2; rd = 2'b01; rs = 2; end
            3'b011: begin ld = 2'b10; ls = 3; rd = 2'b10; rs = 1; end
            3'b100: begin ld = 2'b10; ls = 1; rd = 2'b10; rs = 3; end
            3'b101: begin ld = 2'b01; ls = 2; rd = 2'b10; rs = 2; end
            3'b110: begin ld = 2'b10; ls = 2; rd = 2'b01; rs = 2; end
            default: begin ld = 2'b00; ls = 4; rd = 2'b00; rs = 4; end
        endcase
    endfunction

    function automatic logic pwm_of(input int s);
        case (s)
            0: return pwm_255;
            1: return pwm_250;
            2: return pwm_220;
            3: return pwm_150;
            default: return pwm_0;
        endcase
    endfunction

    // mode: 0 stopped, 1 running, 2 dead-time
    int         m_mode = 0, dead_left = 0, run_len = 1, idle = 0;
    int         m_lsel = 4, m_rsel = 4;
    logic [1:0] m_ld = 0, m_rd = 0;
    bit         m_run = 0, m_trip = 1;
    logic [2:0] last_cmd = 0, m_acc = 0;

    logic [2:0] eff;
    logic [1:0] tld, trd;
    int         tls, trs;
    bit         rev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; dead_left = 0; run_len = 1; idle = 0;
            m_lsel = 4; m_rsel = 4; m_ld = 0; m_rd = 0; m_run = 0; m_trip = 1;
            last_cmd = 0; m_acc = 0;
        end else begin
            eff = m_trip ? 3'b000 : m_acc;
            target(eff, tld, trd, tls, trs);
            rev = (m_ld == 2'b10 && tld == 2'b01) || (m_ld == 2'b01 && tld == 2'b10) ||
                  (m_rd == 2'b10 && trd == 2'b01) || (m_rd == 2'b01 && trd == 2'b10);
            if (tld == 2'b00) begin
                m_mode = 0; m_ld = 0; m_rd = 0; m_run = 0;
            end else if (m_mode == 1 && rev) begin
                m_mode = 2; dead_left = DEAD; m_ld = 0; m_rd = 0; m_run = 0;
            end else if (m_mode == 2) begin
                dead_left--;
                if (dead_left == 0) begin
                    m_mode = 1; m_ld = tld; m_rd = trd; m_lsel = tls; m_rsel = trs; m_run = 1;
                end
            end else begin
                m_mode = 1; m_ld = tld; m_rd = trd; m_lsel = tls; m_rsel = trs; m_run = 1;
            end
            // debounce: a value is taken once seen on STABLE+1 consecutive samples,
            // the reset value counting as already seen once
            if (cmd == last_cmd) begin
                if (run_len < 1000) run_len++;
            end else begin
                last_cmd = cmd; run_len = 1;
            end
            if (run_len > STABLE) m_acc = last_cmd;
            if (cmd_valid) begin
                idle = 0; m_trip = 0;
            end else begin
                if (idle < WDOG) idle++;
                if (idle >= WDOG) m_trip = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("state", 8'(state_o), 8'(m_mode));
        chk("left_in", 8'(left_in), 8'(m_ld));
        chk("right_in", 8'(right_in), 8'(m_rd));
        chk("left_en", 8'(left_en), 8'(m_run && pwm_of(m_lsel)));
        chk("right_en", 8'(right_en), 8'(m_run && pwm_of(m_rsel)));
        chk("wdog_trip", 8'(wdog_trip), 8'(m_trip));
    end

    // ---------------- directed + random stimulus ----------------
    task automatic after_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic [2:0] c);
        @(posedge clk); #2 cmd = c;
    endtask

    initial begin
        int k, n, h;
        bit seen;

        // reset release with fwd held
        cmd = 3'b001;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        after_edges(1);
        chk("t1_trip_e0", 8'(wdog_trip), 8'd1);
        chk("t1_state_e0", 8'(state_o), 8'd0);
        after_edges(1);
        chk("t1_trip_e1", 8'(wdog_trip), 8'd0);
        after_edges(3);
        chk("t1_state_e4", 8'(state_o), 8'd0);
        after_edges(1);
        chk("t1_state_e5", 8'(state_o), 8'd1);
        chk("t1_left_in", 8'(left_in), 8'h2);
        chk("t1_right_in", 8'(right_in), 8'h2);
        chk("t1_left_en", 8'(left_en), 8'(pwm_255));
        after_edges(5);

        // fwd -> back goes through dead time
        set_cmd(3'b010);
        k = 0;
        do begin after_edges(1); k++; end while (state_o != 2'b10 && k < 20);
        chk("t2_dead_entry", 8'(k), 8'd6);
        n = 1;
        while (n < 40) begin
            after_edges(1);
            if (state_o == 2'b10) n++; else break;
        end
        chk("t2_dead_len", 8'(n), 8'd8);
        chk("t2_state", 8'(state_o), 8'd1);
        chk("t2_left_in", 8'(left_in), 8'h1);
        chk("t2_right_in", 8'(right_in), 8'h1);
        chk("t2_left_en", 8'(left_en), 8'(pwm_220));

        // fwd -> turn left: no dead time
        set_cmd(3'b001);
        after_edges(25);
        chk("t3_fwd", 8'(left_in), 8'h2);
        set_cmd(3'b011);
        seen = 0;
        for (int i = 1; i <= 6; i++) begin
            after_edges(1);
            if (state_o == 2'b10) seen = 1;
            if (i == 5) chk("t3_still_fwd", 8'(left_en), 8'(pwm_255));
        end
        chk("t3_no_dead", 8'(seen), 8'd0);
        chk("t3_left_en", 8'(left_en), 8'(pwm_150));
        chk("t3_right_en", 8'(right_en), 8'(pwm_250));
        chk("t3_dirs", 8'({left_in, right_in}), 8'hA);

        // watchdog
        set_cmd(3'b001);
        after_edges(10);
        pulse_en = 1'b0;
        after_edges(85);
        chk("t4_trip_early", 8'(wdog_trip), 8'd0);
        after_edges(30);
        chk("t4_trip", 8'(wdog_trip), 8'd1);
        chk("t4_state", 8'(state_o), 8'd0);
        chk("t4_left_in", 8'(left_in), 8'd0);
        chk("t4_left_en", 8'(left_en), 8'd0);
        pulse_en = 1'b1;
        after_edges(15);
        chk("t4_resume", 8'(state_o), 8'd1);
        chk("t4_resume_dir", 8'(left_in), 8'h2);

        // short glitch is never accepted
        set_cmd(3'b000);
        after_edges(12);
        chk("t5_stop", 8'(state_o), 8'd0);
        set_cmd(3'b001);
        repeat (2) @(posedge clk);
        #2 cmd = 3'b000;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            after_edges(1);
            if (state_o != 2'b00 || left_in != 2'b00) seen = 1;
        end
        chk("t5_glitch", 8'(seen), 8'd0);

        // reset in the middle of dead time
        set_cmd(3'b001);
        after_edges(12);
        chk("t6_run", 8'(state_o), 8'd1);
        set_cmd(3'b010);
        k = 0;
        do begin after_edges(1); k++; end while (state_o != 2'b10 && k < 20);
        chk("t6_dead", 8'(state_o), 8'h2);
        after_edges(2);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_state", 8'(state_o), 8'd0);
        chk("t6_rst_dirs", 8'({left_in, right_in}), 8'd0);
        chk("t6_rst_en", 8'({left_en, right_en}), 8'd0);
        chk("t6_rst_trip", 8'(wdog_trip), 8'd1);
        after_edges(2);
        @(posedge clk); #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            after_edges(1);
            if (state_o == 2'b10) seen = 1;
        end
        chk("t6_no_dead", 8'(seen), 8'd0);
        chk("t6_rev", 8'({state_o, left_in}), 8'h5);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            cmd = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 14) == 0) pulse_en = !pulse_en;
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #2 rst_n = 1'b1;
            end
            h = $urandom_range(0, 13);
            repeat (h) @(posedge clk);
        end

        after_edges(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
